// File: rtl/adder_pkg.sv
// Shared types and constants for the registered adder.
// ADDER_FLAGS_EN (optional define) adds registered carry/overflow flags.
package adder_pkg;

  localparam int ADDER_W = 32;

  typedef logic [ADDER_W-1:0] word_t;

  typedef struct packed {
    logic carry;
    logic overflow;
  } add_flags_t;

endpackage : adder_pkg

// File: rtl/adder_core.sv
// Combinational N-bit modulo-2^N adder.
// With ADDER_FLAGS_EN defined it also produces carry-out and signed overflow.
module adder_core
  import adder_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef ADDER_FLAGS_EN
  output add_flags_t   flags,
`endif
  output logic [N-1:0] sum
);

`ifdef ADDER_FLAGS_EN
  logic [N:0] full;

  // Zero-extend both operands so bit N of the result is the unsigned carry.
  assign full           = {1'b0, a} + {1'b0, b};
  assign sum            = full[N-1:0];
  assign flags.carry    = full[N];
  assign flags.overflow = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
`else
  assign sum = a + b;
`endif

endmodule : adder_core

// File: rtl/adder_reg.sv
// Adder with a one-cycle registered result stage and valid pulse.
// ADDER_FLAGS_EN defined: carry/overflow ports and registers are present.
module adder_reg
  import adder_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
`ifdef ADDER_FLAGS_EN
  output logic         carry,
  output logic         overflow,
`endif
  output logic [N-1:0] out
);

  logic [N-1:0] sum;

`ifdef ADDER_FLAGS_EN
  add_flags_t flags_d;
  add_flags_t flags_q;
`endif

  adder_core #(.N(N)) u_core (
    .a     (in1),
    .b     (in2),
`ifdef ADDER_FLAGS_EN
    .flags (flags_d),
`endif
    .sum   (sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid;
      // Operands are only captured when valid, so idle X inputs never reach out.
      if (in_valid) out <= sum;
    end
  end

`ifdef ADDER_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flags_q <= '0;
    else if (in_valid) flags_q <= flags_d;
  end

  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
`endif

endmodule : adder_reg

// File: tb/tb_adder_reg.sv
// Self-checking bench for adder_reg: directed table, hold/reset sequences and
// a randomized stream against an arithmetic reference model.
module tb_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        out_valid;
  logic [31:0] out;
`ifdef ADDER_FLAGS_EN
  logic        carry;
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  // Expected registered state, maintained by the bench itself.
  logic [31:0] exp_out = '0;
  logic        exp_c   = 1'b0;
  logic        exp_v   = 1'b0;

  always #5 clk = ~clk;

  adder_reg #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
`ifdef ADDER_FLAGS_EN
    .carry     (carry),
    .overflow  (overflow),
`endif
    .out       (out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum wraps at 2^32; overflow when the true signed sum
  // leaves the 32-bit signed range.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] s, output logic c, output logic v);
    longint us;
    longint ss;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a)) + longint'($signed(b));
    s  = us[31:0];
    c  = (us >= 64'sd4294967296);
    v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
  endfunction

  // Drive one cycle at the falling edge, then check #1 after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] s;
    logic        c;
    logic        o;
    @(negedge clk);
    in_valid = v;
    in1      = a;
    in2      = b;
    if (v) begin
      model(a, b, s, c, o);
      exp_out = s;
      exp_c   = c;
      exp_v   = o;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out"}, 64'(out), 64'(exp_out));
`ifdef ADDER_FLAGS_EN
    check({tag, ".carry"}, 64'(carry), 64'(exp_c));
    check({tag, ".overflow"}, 64'(overflow), 64'(exp_v));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out"}, 64'(out), 64'd0);
`ifdef ADDER_FLAGS_EN
    check({tag, ".carry"}, 64'(carry), 64'd0);
    check({tag, ".overflow"}, 64'(overflow), 64'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFB, 32'h0000_0008, 32'h0000_0003, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

    // Reset state while rst_n is held low across clock edges.
    @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, applied back-to-back; expectations come from the table.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in1      = vecs[i].a;
      in2      = vecs[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d.out", i), 64'(out), 64'(vecs[i].s));
`ifdef ADDER_FLAGS_EN
      check($sformatf("vec%0d.carry", i), 64'(carry), 64'(vecs[i].c));
      check($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(vecs[i].v));
`endif
      exp_out = vecs[i].s;
      exp_c   = vecs[i].c;
      exp_v   = vecs[i].v;
    end

    // 0 + 0, then three idle cycles with junk operands: out must hold 0.
    cycle(1'b1, 32'h0, 32'h0, "zero");
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, $urandom, $sformatf("idle%0d", i));

    // Hold of a non-zero result across idle cycles.
    cycle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "hold_src");
    for (int i = 0; i < 2; i++) cycle(1'b0, $urandom, $urandom, $sformatf("hold%0d", i));

    // Randomized stream with random valid gaps against the reference model.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, $sformatf("rnd%0d", i));
    end

    // Back-to-back stream interrupted by an asynchronous reset mid-cycle.
    cycle(1'b1, 32'h0000_0010, 32'h0000_0020, "stream0");
    cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "stream1");
    @(negedge clk);
    in1 = 32'hFFFF_FFFF;
    in2 = 32'h0000_0002;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    in1 = 32'h1111_1111;
    in2 = 32'h2222_2222;
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_out  = '0;
    exp_c    = 1'b0;
    exp_v    = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_release");

    // Normal operation resumes after reset.
    cycle(1'b1, 32'hFFFF_FFFB, 32'h0000_0008, "post_rst");
    cycle(1'b0, $urandom, $urandom, "post_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adder_reg
